phase_sequencer: RTL and testbench
==================================

// Module: phase_sequencer
// PURPOSE
//  Two-phase FETCH/EXEC sequencer for the nic8 CPU. Gates the instruction decoder so IR
//  loads only in FETCH and register/memory effects only in EXEC. Provides run/halt/
//  single-step debug control. Arbitrates the shared ROM/RAM bus between the CPU and an
//  external program loader. Sits between the front-panel/loader logic and the decoder.
// PARAMETERS
//  COUNT_W      16     width of retired-instruction counter
//  HALT_OPCODE  8'h70  IR value (dest=7, source=0) that halts the CPU after its EXEC
// PORTS
//  clk          in   1        system clock, all state changes on posedge
//  resetBar     in   1        synchronous, active-low reset
//  run          in   1        level: 1 = free-run, 0 = stop at next instruction boundary
//  stepReq      in   1        1-cycle pulse: execute exactly one instruction while halted
//  ir           in   8        current IR contents (valid from the cycle after FETCH)
//  loadReq      in   1        loader requests the bus; held until loadAck seen, then until done
//  loadAck      out  1        bus granted to loader; CPU frozen
//  fetchEnBar   out  1        low in FETCH: decoder forces IR load from ROM[PC], PC++
//  execEnBar    out  1        low in EXEC: decoder dest/source strobes allowed
//  halted       out  1        1 in HALTED state
//  instrCount   out  COUNT_W  retired-instruction count
// BEHAVIOUR
//  States: RESET, FETCH, EXEC, HALTED, LOAD (encoded in shared package).
//  Reset (resetBar=0 at posedge): state<=RESET; fetchEnBar=1, execEnBar=1, halted=0,
//   loadAck=0, instrCount=0. Applies mid-FETCH/EXEC/LOAD; a loader grant drops at once.
//  All outputs registered/decoded from state only; no combinational input->output path.
//  RESET: next = LOAD if loadReq, else FETCH if run, else HALTED.
//  FETCH (1 cycle): fetchEnBar=0. next = EXEC unconditionally.
//  EXEC (1 cycle): execEnBar=0; instrCount += 1 at end (wraps 2^COUNT_W-1 -> 0).
//   next priority: loadReq -> LOAD; ir==HALT_OPCODE -> HALTED; run=0 -> HALTED;
//   stepLatched -> HALTED (clears it); else FETCH.
//  HALTED: halted=1. next: loadReq -> LOAD; run=1 -> FETCH; stepReq -> FETCH (sets
//   stepLatched). A halt opcode is resumed past by run/step (PC already advanced).
//  LOAD: loadAck=1, both enables high. Stays while loadReq=1. On loadReq=0 -> HALTED
//   (never directly to FETCH; loader finishing never auto-runs).
//  Instruction boundary = end of EXEC or HALTED; the CPU is never preempted mid-instruction.
//  stepReq outside HALTED (and not in RESET with run=0) is ignored, not queued.
//  Simultaneous loadReq+run, or loadReq+stepReq, in HALTED: LOAD wins; step dropped.
//  fetchEnBar and execEnBar are never both low; loadAck=1 implies both high.
//  Latency: run 0->1 while HALTED -> FETCH next cycle; loadReq at EXEC -> loadAck after 1 cycle;
//   worst case loadReq in FETCH -> loadAck after 2 cycles.
// STRUCTURE
//  Package nic8_pkg: state enum (RESET..LOAD), HALT_OPCODE default, bus-owner constants.
//  One sub-module: retire_counter (COUNT_W-bit synchronous counter, synch clear, inc enable),
//   reused by the front-panel display. FSM + step latch stay in phase_sequencer.
// TESTING
//  1 Reset: resetBar=0 2 cycles, run=1 -> release; FETCH,EXEC alternate; instrCount=1,2,3
//    after cycles 2,4,6; fetchEnBar/execEnBar never both low.
//  2 Halt opcode: ir=8'h70 in EXEC with run=1 -> HALTED next cycle, halted=1, count frozen;
//    stepReq pulse -> exactly one FETCH+EXEC, count+1, back to HALTED.
//  3 Run drop: run 1->0 during FETCH -> current EXEC completes, then HALTED; stepReq pulses
//    while running have no effect (count unchanged vs. reference model).
//  4 Loader: loadReq=1 during FETCH -> EXEC finishes, loadAck=1 two cycles later; hold 10
//    cycles (count constant); loadReq=0 -> HALTED even with run=1, FETCH on following cycle.
//  5 Contention: in HALTED assert loadReq+stepReq same cycle -> LOAD, no EXEC, step lost.
//  6 Wrap/reset: COUNT_W=4, run 16 instrs -> instrCount=0; resetBar=0 mid-LOAD -> loadAck=0
//    next cycle, count=0.

Source files
------------

// File: rtl/nic8_pkg.sv
// Shared definitions for the nic8 phase sequencer: state codes, halt opcode and bus ownership.
package nic8_pkg;

  typedef enum logic [2:0] {
    STATE_RESET  = 3'd0,
    STATE_FETCH  = 3'd1,
    STATE_EXEC   = 3'd2,
    STATE_HALTED = 3'd3,
    STATE_LOAD   = 3'd4
  } state_e;

  // Plain vector codes so the FSM register stays a simple logic vector.
  localparam logic [2:0] ST_RESET  = STATE_RESET;
  localparam logic [2:0] ST_FETCH  = STATE_FETCH;
  localparam logic [2:0] ST_EXEC   = STATE_EXEC;
  localparam logic [2:0] ST_HALTED = STATE_HALTED;
  localparam logic [2:0] ST_LOAD   = STATE_LOAD;

  localparam logic [7:0] HALT_OPCODE_DFLT = 8'h70;

  typedef enum logic {
    BUS_OWNER_CPU    = 1'b0,
    BUS_OWNER_LOADER = 1'b1
  } bus_owner_e;

  function automatic bus_owner_e bus_owner(input logic [2:0] st);
    return (st == ST_LOAD) ? BUS_OWNER_LOADER : BUS_OWNER_CPU;
  endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Control/status bundle between the front-panel/loader logic and the phase sequencer.
interface phase_sequencer_if #(
  parameter int COUNT_W = 16
);
  logic               run;
  logic               stepReq;
  logic [7:0]         ir;
  logic               loadReq;
  logic               loadAck;
  logic               fetchEnBar;
  logic               execEnBar;
  logic               halted;
  logic [COUNT_W-1:0] instrCount;

  modport master (
    output run, stepReq, ir, loadReq,
    input  loadAck, fetchEnBar, execEnBar, halted, instrCount
  );

  modport slave (
    input  run, stepReq, ir, loadReq,
    output loadAck, fetchEnBar, execEnBar, halted, instrCount
  );
endinterface

// File: rtl/retire_counter.sv
// Wrapping retired-instruction counter with synchronous clear and increment enable.
module retire_counter #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               resetBar,
  input  logic               clr,
  input  logic               inc_en,
  output logic [COUNT_W-1:0] count
);

  logic [COUNT_W-1:0] count_d;
  logic [COUNT_W-1:0] count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc_en) begin
      count_d = count_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetBar) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/phase_sequencer.sv
// Two-phase FETCH/EXEC sequencer with run/halt/single-step control and loader bus arbitration.
module phase_sequencer
  import nic8_pkg::*;
#(
  parameter int         COUNT_W     = 16,
  parameter logic [7:0] HALT_OPCODE = HALT_OPCODE_DFLT
) (
  input  logic               clk,
  input  logic               resetBar,
  phase_sequencer_if.slave   bus
);

  logic [2:0]         state_d;
  logic [2:0]         state_q;
  logic               step_lat_d;
  logic               step_lat_q;
  logic [COUNT_W-1:0] count;

  always_comb begin
    state_d    = state_q;
    step_lat_d = step_lat_q;
    case (state_q)
      ST_RESET: begin
        if (bus.loadReq) begin
          state_d = ST_LOAD;
        end else if (bus.run) begin
          state_d = ST_FETCH;
        end else if (bus.stepReq) begin
          state_d    = ST_FETCH;
          step_lat_d = 1'b1;
        end else begin
          state_d = ST_HALTED;
        end
      end
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC: begin
        // Any step request is consumed at the end of the instruction it started.
        step_lat_d = 1'b0;
        if (bus.loadReq) begin
          state_d = ST_LOAD;
        end else if (bus.ir == HALT_OPCODE) begin
          state_d = ST_HALTED;
        end else if (!bus.run) begin
          state_d = ST_HALTED;
        end else if (step_lat_q) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_HALTED: begin
        if (bus.loadReq) begin
          state_d = ST_LOAD;
        end else if (bus.run) begin
          state_d = ST_FETCH;
        end else if (bus.stepReq) begin
          state_d    = ST_FETCH;
          step_lat_d = 1'b1;
        end
      end
      ST_LOAD: begin
        // Loader release always parks the CPU; resuming needs run or step.
        if (!bus.loadReq) begin
          state_d = ST_HALTED;
        end
      end
      default: begin
        state_d    = ST_RESET;
        step_lat_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetBar) begin
      state_q    <= ST_RESET;
      step_lat_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_lat_q <= step_lat_d;
    end
  end

  retire_counter #(
    .COUNT_W (COUNT_W)
  ) u_retire_counter (
    .clk      (clk),
    .resetBar (resetBar),
    .clr      (1'b0),
    .inc_en   (state_q == ST_EXEC),
    .count    (count)
  );

  assign bus.fetchEnBar = (state_q != ST_FETCH);
  assign bus.execEnBar  = (state_q != ST_EXEC);
  assign bus.halted     = (state_q == ST_HALTED);
  assign bus.loadAck    = (bus_owner(state_q) == BUS_OWNER_LOADER);
  assign bus.instrCount = count;

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer: directed cycles push expected phase/count, a monitor checks.
module tb_phase_sequencer;

  localparam int CW = 4;

  logic clk = 1'b0;
  logic resetBar;

  phase_sequencer_if #(.COUNT_W(CW)) bus ();

  phase_sequencer #(
    .COUNT_W     (CW),
    .HALT_OPCODE (8'h70)
  ) dut (
    .clk      (clk),
    .resetBar (resetBar),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    byte   ph;
    int    cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Expected {fetchEnBar, execEnBar, halted, loadAck} for each phase letter.
  function automatic logic [3:0] flags(input byte ph);
    case (ph)
      "R":     return 4'b1100;
      "F":     return 4'b0100;
      "E":     return 4'b1000;
      "H":     return 4'b1110;
      "L":     return 4'b1101;
      default: return 4'bxxxx;
    endcase
  endfunction

  initial begin : monitor
    exp_t           e;
    logic [3:0]     got_f;
    logic [3:0]     want_f;
    logic [CW-1:0]  got_c;
    logic [CW-1:0]  want_c;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e      = sb_q.pop_front();
        got_f  = {bus.fetchEnBar, bus.execEnBar, bus.halted, bus.loadAck};
        want_f = flags(e.ph);
        got_c  = bus.instrCount;
        want_c = e.cnt[CW-1:0];
        n_cmp++;
        if (got_f !== want_f || got_c !== want_c) begin
          n_bad++;
          $display("FAIL %s: got fe/ee/h/ack=%b cnt=%0d, want %b (%s) cnt=%0d",
                   e.name, got_f, got_c, want_f, e.ph, want_c);
        end else begin
          $display("ok   %s: phase %s cnt=%0d", e.name, e.ph, got_c);
        end
        n_cmp++;
        if ((!bus.fetchEnBar && !bus.execEnBar) ||
            (bus.loadAck && !(bus.fetchEnBar && bus.execEnBar))) begin
          n_bad++;
          $display("FAIL %s.enables: got fe=%b ee=%b ack=%b, want enables exclusive and high under ack",
                   e.name, bus.fetchEnBar, bus.execEnBar, bus.loadAck);
        end
      end
    end
  end

  task automatic cyc(input string nm, input bit rb, input bit r, input bit s, input bit l,
                     input logic [7:0] irv, input byte ph, input int cnt);
    exp_t e;
    resetBar    = rb;
    bus.run     = r;
    bus.stepReq = s;
    bus.loadReq = l;
    bus.ir      = irv;
    e.name = nm;
    e.ph   = ph;
    e.cnt  = cnt;
    sb_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  initial begin : watchdog
    #20000;
    $display("FAIL watchdog: got no finish, want finish before 20000");
    $fatal(1);
  end

  initial begin : stim
    resetBar    = 1'b0;
    bus.run     = 1'b1;
    bus.stepReq = 1'b0;
    bus.loadReq = 1'b0;
    bus.ir      = 8'h00;
    @(posedge clk);
    #2;

    // 1: reset then free-run
    cyc("t1.rst0",  0, 1, 0, 0, 8'h00, "R", 0);
    cyc("t1.rst1",  0, 1, 0, 0, 8'h00, "R", 0);
    cyc("t1.f0",    1, 1, 0, 0, 8'h00, "F", 0);
    cyc("t1.e0",    1, 1, 0, 0, 8'h00, "E", 0);
    cyc("t1.f1",    1, 1, 0, 0, 8'h00, "F", 1);
    cyc("t1.e1",    1, 1, 0, 0, 8'h00, "E", 1);
    cyc("t1.f2",    1, 1, 0, 0, 8'h00, "F", 2);
    cyc("t1.e2",    1, 1, 0, 0, 8'h00, "E", 2);
    cyc("t1.f3",    1, 1, 0, 0, 8'h00, "F", 3);

    // 2: halt opcode, then a single step with run rising mid-step
    cyc("t2.e3",    1, 1, 0, 0, 8'h00, "E", 3);
    cyc("t2.halt",  1, 1, 0, 0, 8'h70, "H", 4);
    cyc("t2.hold0", 1, 0, 0, 0, 8'h00, "H", 4);
    cyc("t2.hold1", 1, 0, 0, 0, 8'h00, "H", 4);
    cyc("t2.stepf", 1, 0, 1, 0, 8'h00, "F", 4);
    cyc("t2.stepe", 1, 1, 0, 0, 8'h00, "E", 4);
    cyc("t2.steph", 1, 1, 0, 0, 8'h00, "H", 5);
    cyc("t2.runf",  1, 1, 0, 0, 8'h00, "F", 5);
    cyc("t2.rune",  1, 1, 0, 0, 8'h00, "E", 5);
    cyc("t2.runf2", 1, 1, 0, 0, 8'h00, "F", 6);

    // 3: step pulses while running are ignored; run drop in FETCH finishes EXEC
    cyc("t3.se0",   1, 1, 1, 0, 8'h00, "E", 6);
    cyc("t3.sf0",   1, 1, 0, 0, 8'h00, "F", 7);
    cyc("t3.se1",   1, 1, 1, 0, 8'h00, "E", 7);
    cyc("t3.sf1",   1, 1, 1, 0, 8'h00, "F", 8);
    cyc("t3.drop",  1, 0, 0, 0, 8'h00, "E", 8);
    cyc("t3.halt",  1, 0, 0, 0, 8'h00, "H", 9);
    cyc("t3.hold",  1, 0, 0, 0, 8'h00, "H", 9);

    // 4: loader request during FETCH
    cyc("t4.f",     1, 1, 0, 0, 8'h00, "F", 9);
    cyc("t4.reqf",  1, 1, 0, 1, 8'h00, "E", 9);
    cyc("t4.ack",   1, 1, 0, 1, 8'h00, "L", 10);
    for (int i = 0; i < 10; i++) begin
      cyc("t4.hold", 1, 1, 0, 1, 8'h00, "L", 10);
    end
    cyc("t4.done",  1, 1, 0, 0, 8'h00, "H", 10);
    cyc("t4.resum", 1, 1, 0, 0, 8'h00, "F", 10);
    cyc("t4.e",     1, 0, 0, 0, 8'h00, "E", 10);
    cyc("t4.h",     1, 0, 0, 0, 8'h00, "H", 11);

    // 5: contention in HALTED
    cyc("t5.lsstep", 1, 0, 1, 1, 8'h00, "L", 11);
    cyc("t5.lhold",  1, 0, 0, 1, 8'h00, "L", 11);
    cyc("t5.ldone",  1, 0, 0, 0, 8'h00, "H", 11);
    cyc("t5.nostep", 1, 0, 0, 0, 8'h00, "H", 11);
    cyc("t5.lrun",   1, 1, 0, 1, 8'h00, "L", 11);
    cyc("t5.ldone2", 1, 1, 0, 0, 8'h00, "H", 11);
    cyc("t5.idle",   1, 0, 0, 0, 8'h00, "H", 11);

    // 6: counter wrap, then reset in the middle of a load
    cyc("t6.f",      1, 1, 0, 0, 8'h00, "F", 11);
    for (int i = 0; i < 5; i++) begin
      cyc("t6.exec",  1, 1, 0, 0, 8'h00, "E", 11 + i);
      cyc("t6.fetch", 1, 1, 0, 0, 8'h00, "F", (12 + i) % 16);
    end
    cyc("t6.reqf",   1, 1, 0, 1, 8'h00, "E", 0);
    cyc("t6.ack",    1, 1, 0, 1, 8'h00, "L", 1);
    cyc("t6.lhold",  1, 1, 0, 1, 8'h00, "L", 1);
    cyc("t6.rstld",  0, 1, 0, 1, 8'h00, "R", 0);
    cyc("t6.reload", 1, 0, 0, 1, 8'h00, "L", 0);
    cyc("t6.ldone",  1, 0, 0, 0, 8'h00, "H", 0);
    cyc("t6.runf",   1, 1, 0, 0, 8'h00, "F", 0);
    cyc("t6.rune",   1, 0, 0, 0, 8'h00, "E", 0);
    cyc("t6.endh",   1, 0, 0, 0, 8'h00, "H", 1);

    for (int k = 0; k < 4 && sb_q.size() > 0; k++) begin
      @(posedge clk);
      #2;
    end
    if (sb_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
